// File: rtl/rega_pkg.sv
// rega_pkg: shared types and constants for the irrigation phase-counter
// controller.
//   state_t     - controller FSM state encoding
//   ctrl_out_t  - bundle of the registered Moore outputs
//   CNT_PRESET  - value the counter is preset to when Pos3 is asserted
//   CNT_CLEAR   - value the counter holds when Pos0 is asserted
//   decode_out  - maps a state to its output bundle
package rega_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  typedef struct packed {
    logic y;
    logic pos0;
    logic pos3;
    logic valve;
    logic done;
    logic fault;
  } ctrl_out_t;

  localparam logic [1:0] CNT_PRESET = 2'd3;
  localparam logic [1:0] CNT_CLEAR  = 2'd0;

  function automatic ctrl_out_t decode_out(state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_IDLE:  o.pos0 = 1'b1;
      S_LOAD:  o.pos3 = 1'b1;
      S_RUN:   o.valve = 1'b1;        // y stays 0: counter runs down
      S_DRAIN: o.pos0 = 1'b1;
      S_DONE:  begin o.done = 1'b1; o.pos0 = 1'b1; end
      S_FAULT: begin o.fault = 1'b1; o.pos0 = 1'b1; end
      default: o.pos0 = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mod4_shadow.sv
// mod4_shadow: expected-count model of the 2-bit down counter.
//   clk, rst_n - clock and asynchronous active-low reset (value resets to 0)
//   load       - load CNT_PRESET at the next edge
//   dec        - decrement mod 4 at the next edge
//   q          - count observed from the real counter
//   match      - high while q equals the shadow value
module mod4_shadow
  import rega_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [1:0] q,
  output logic       match
);

  logic [1:0] value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= CNT_CLEAR;
    end else if (load) begin
      value <= CNT_PRESET;
    end else if (dec) begin
      value <= value - 2'd1;
    end
  end

  assign match = (value == q);

endmodule

// File: rtl/rega_cont_ctrl.sv
// rega_cont_ctrl: command-side controller for the cont_mod4 phase counter.
// Opens the valve for Dur complete counter turns, checks every returned
// count against a shadow model and reports completion or a sticky fault.
//   Clk, Rstn        - clock, asynchronous active-low reset
//   Start, Stop, Dry - cycle request, abort (priority), soil-dry sensor
//   Dur              - turns to irrigate, captured on an accepted Start
//   Q1, Q0           - count fed back from the counter
//   Y, Pos0, Pos3    - counter direction, clear, preset-to-3
//   Valve, Done      - valve open, one-cycle completion pulse
//   Fault            - sticky feedback-mismatch flag
//
// state | meaning
// IDLE  | counter held clear, waiting for Start & Dry
// LOAD  | counter preset to 3
// RUN   | valve open, counter runs down, feedback checked every cycle
// DRAIN | valve closed, counter cleared; picks DONE or IDLE
// DONE  | one-cycle completion pulse
// FAULT | feedback mismatch seen; held until Stop
module rega_cont_ctrl
  import rega_pkg::*;
#(
  parameter int DUR_W = 8
)
(
  input  logic             Clk,
  input  logic             Rstn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Dry,
  input  logic [DUR_W-1:0] Dur,
  input  logic             Q1,
  input  logic             Q0,
  output logic             Y,
  output logic             Pos0,
  output logic             Pos3,
  output logic             Valve,
  output logic             Done,
  output logic             Fault
);

  state_t           state;
  state_t           state_nxt;
  ctrl_out_t        outs;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] turns;
  logic [DUR_W-1:0] turns_inc_val;
  logic             done_flag;
  logic             cap;
  logic             inc;
  logic             done_set;
  logic             shadow_load;
  logic             shadow_dec;
  logic             match;
  logic [1:0]       q;

  assign q             = {Q1, Q0};
  assign turns_inc_val = turns + DUR_W'(1);

  mod4_shadow u_shadow (
    .clk   (Clk),
    .rst_n (Rstn),
    .load  (shadow_load),
    .dec   (shadow_dec),
    .q     (q),
    .match (match)
  );

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state <= S_IDLE;
      outs  <= decode_out(S_IDLE);
    end else begin
      state <= state_nxt;
      outs  <= decode_out(state_nxt);
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      dur_q     <= '0;
      turns     <= '0;
      done_flag <= 1'b0;
    end else if (cap) begin
      dur_q     <= Dur;
      turns     <= '0;
      done_flag <= 1'b0;
    end else begin
      if (inc)      turns     <= turns_inc_val;
      if (done_set) done_flag <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cap         = 1'b0;
    inc         = 1'b0;
    done_set    = 1'b0;
    shadow_load = 1'b0;
    shadow_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start && Dry && !Stop) begin
          cap       = 1'b1;
          state_nxt = (Dur == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (Stop) begin
          state_nxt = S_DRAIN;
        end else begin
          // Counter is preset to 3 on this same edge; shadow follows.
          shadow_load = 1'b1;
          state_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        shadow_dec = 1'b1;
        if (!match) begin
          state_nxt = S_FAULT;
        end else if (Stop) begin
          state_nxt = S_DRAIN;
        end else if (q == CNT_CLEAR) begin
          inc = 1'b1;
          if (turns_inc_val == dur_q) begin
            done_set  = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_nxt = done_flag ? S_DONE : S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: if (Stop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Y     = outs.y;
  assign Pos0  = outs.pos0;
  assign Pos3  = outs.pos3;
  assign Valve = outs.valve;
  assign Done  = outs.done;
  assign Fault = outs.fault;

endmodule

// File: tb/tb_rega_cont_ctrl.sv
// tb_rega_cont_ctrl: directed bench for rega_cont_ctrl with a behavioural
// cont_mod4 counter model on the feedback path.
module tb_rega_cont_ctrl;

  logic       Clk;
  logic       Rstn;
  logic       Start;
  logic       Stop;
  logic       Dry;
  logic [7:0] Dur;
  logic       Q1;
  logic       Q0;
  logic       Y;
  logic       Pos0;
  logic       Pos3;
  logic       Valve;
  logic       Done;
  logic       Fault;

  logic [1:0] cnt;
  logic       force_en;
  logic [1:0] force_val;
  logic [1:0] q_mux;

  int n_checks;
  int n_fail;

  int valve_cnt, valve_first, pos3_cnt, done_cnt, done_at;
  int fault_cnt, fault_first, pos0_cnt;
  logic fault_last, pos0_last;

  rega_cont_ctrl #(.DUR_W(8)) dut (
    .Clk   (Clk),
    .Rstn  (Rstn),
    .Start (Start),
    .Stop  (Stop),
    .Dry   (Dry),
    .Dur   (Dur),
    .Q1    (Q1),
    .Q0    (Q0),
    .Y     (Y),
    .Pos0  (Pos0),
    .Pos3  (Pos3),
    .Valve (Valve),
    .Done  (Done),
    .Fault (Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // cont_mod4 model: clear beats preset, otherwise count by Y.
  initial cnt = 2'd0;
  always @(posedge Clk) begin
    if (Pos0)      cnt <= 2'd0;
    else if (Pos3) cnt <= 2'd3;
    else if (Y)    cnt <= cnt + 2'd1;
    else           cnt <= cnt - 2'd1;
  end

  assign q_mux = force_en ? force_val : cnt;
  assign Q1    = q_mux[1];
  assign Q0    = q_mux[0];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Enter with time just after a rising edge; Start is sampled at the next edge.
  task automatic start_cycle(input logic [7:0] d);
    Start = 1'b1;
    Dur   = d;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Observe ncyc cycles; cycle n is the interval after the n-th edge.
  task automatic observe(input int ncyc, input int force_at, input logic [1:0] force_v,
                         input int stop_at, input int start_at);
    valve_cnt = 0; valve_first = 0; pos3_cnt = 0; done_cnt = 0; done_at = 0;
    fault_cnt = 0; fault_first = 0; pos0_cnt = 0;
    for (int n = 1; n <= ncyc; n++) begin
      force_en  = (n == force_at);
      force_val = force_v;
      Stop      = (n == stop_at);
      Start     = (n == start_at);
      @(negedge Clk);
      if (Valve) begin valve_cnt++; if (valve_first == 0) valve_first = n; end
      if (Pos3)  pos3_cnt++;
      if (Done)  begin done_cnt++; if (done_at == 0) done_at = n; end
      if (Fault) begin fault_cnt++; if (fault_first == 0) fault_first = n; end
      if (Pos0)  pos0_cnt++;
      fault_last = Fault;
      pos0_last  = Pos0;
      @(posedge Clk);
      #1;
    end
    force_en = 1'b0;
    Stop     = 1'b0;
    Start    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rstn = 1'b0; Start = 1'b0; Stop = 1'b0; Dry = 1'b1; Dur = 8'd0;
    force_en = 1'b0; force_val = 2'd0;

    // Reset values
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_val("rst_y",     Y,     0);
    check_val("rst_pos0",  Pos0,  1);
    check_val("rst_pos3",  Pos3,  0);
    check_val("rst_valve", Valve, 0);
    check_val("rst_done",  Done,  0);
    check_val("rst_fault", Fault, 0);
    @(posedge Clk); #1;
    Rstn = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end

    // Normal run, Dur=2; Dur scrambled and Dry dropped after capture
    start_cycle(8'd2);
    Dur = 8'hFF;
    Dry = 1'b0;
    observe(14, 0, 2'd0, 0, 0);
    check_val("norm_valve_cnt",   valve_cnt,   8);
    check_val("norm_valve_first", valve_first, 2);
    check_val("norm_pos3_cnt",    pos3_cnt,    1);
    check_val("norm_done_cnt",    done_cnt,    1);
    check_val("norm_done_at",     done_at,     11);
    check_val("norm_fault_cnt",   fault_cnt,   0);
    check_val("norm_idle_pos0",   pos0_last,   1);
    Dry = 1'b1;

    // Dur=0: straight to DONE
    start_cycle(8'd0);
    observe(5, 0, 2'd0, 0, 0);
    check_val("dur0_valve_cnt", valve_cnt, 0);
    check_val("dur0_pos3_cnt",  pos3_cnt,  0);
    check_val("dur0_done_cnt",  done_cnt,  1);
    check_val("dur0_done_at",   done_at,   1);

    // Start with Dry=0: stays in IDLE
    Dry = 1'b0;
    start_cycle(8'd2);
    observe(6, 0, 2'd0, 0, 0);
    check_val("dry0_pos0_cnt",  pos0_cnt,  6);
    check_val("dry0_valve_cnt", valve_cnt, 0);
    check_val("dry0_pos3_cnt",  pos3_cnt,  0);
    check_val("dry0_done_cnt",  done_cnt,  0);
    check_val("dry0_fault_cnt", fault_cnt, 0);
    Dry = 1'b1;

    // Dur=3, Q forced to 2 on the 5th RUN cycle (cycle 6), Stop on cycle 11
    start_cycle(8'd3);
    observe(12, 6, 2'd2, 11, 0);
    check_val("flt_first",     fault_first, 7);
    check_val("flt_cnt",       fault_cnt,   5);
    check_val("flt_valve_cnt", valve_cnt,   5);
    check_val("flt_done_cnt",  done_cnt,    0);
    check_val("flt_cleared",   fault_last,  0);
    check_val("flt_idle_pos0", pos0_last,   1);

    // Dur=1, Stop on the final Q=0 cycle (5); restart on cycle 7
    start_cycle(8'd1);
    observe(16, 0, 2'd0, 5, 7);
    check_val("stop_valve_cnt", valve_cnt, 8);
    check_val("stop_pos3_cnt",  pos3_cnt,  2);
    check_val("stop_done_cnt",  done_cnt,  1);
    check_val("stop_done_at",   done_at,   14);

    // Stop during LOAD aborts
    start_cycle(8'd2);
    observe(6, 0, 2'd0, 1, 0);
    check_val("ldstop_valve_cnt", valve_cnt, 0);
    check_val("ldstop_done_cnt",  done_cnt,  0);

    // Async reset mid-RUN
    start_cycle(8'd3);
    observe(4, 0, 2'd0, 0, 0);
    check_val("arst_pre_valve", Valve, 1);
    #2;
    Rstn = 1'b0;
    #1;
    check_val("arst_valve", Valve, 0);
    check_val("arst_pos0",  Pos0,  1);
    check_val("arst_fault", Fault, 0);
    check_val("arst_pos3",  Pos3,  0);
    @(posedge Clk); #1;
    Rstn = 1'b1;
    @(posedge Clk); #1;
    start_cycle(8'd2);
    observe(14, 0, 2'd0, 0, 0);
    check_val("arst_run_valve_cnt", valve_cnt, 8);
    check_val("arst_run_done_at",   done_at,   11);
    check_val("arst_run_fault_cnt", fault_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
